// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin path allocator holding each input->output path until the packet tail
module switch_allocator #(
   parameter int INPUTS        = 4,
   parameter int OUTPUTS       = 4,
   parameter int REQUEST_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [INPUTS-1:0]                  req_valid,
   input  logic [INPUTS*REQUEST_WIDTH-1:0]    req_port,
   input  logic [INPUTS-1:0]                  valid_in,
   input  logic [INPUTS-1:0]                  ready_in,
   input  logic [INPUTS-1:0]                  tail_in,
   output logic [OUTPUTS*REQUEST_WIDTH-1:0]   routeSelect,
   output logic [OUTPUTS-1:0]                 outputBusy,
   output logic [INPUTS-1:0]                  PortReserved,
   output logic [INPUTS-1:0]                  grant
);
   localparam int IW = INPUTS > 1 ? $clog2(INPUTS) : 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t                   st_q  [OUTPUTS];
   state_t                   st_d  [OUTPUTS];
   logic [IW-1:0]            own_q [OUTPUTS];
   logic [IW-1:0]            own_d [OUTPUTS];
   logic [IW-1:0]            ptr_q [OUTPUTS];
   logic [IW-1:0]            ptr_d [OUTPUTS];
   logic [INPUTS-1:0]        grant_q, grant_d, hs, reserved;
   logic [REQUEST_WIDTH-1:0] field [INPUTS];
   logic [IW-1:0]            idx;
   logic                     found;
   int                       s;
   assign hs           = valid_in & ready_in & tail_in;
   assign PortReserved = reserved;
   assign grant        = grant_q;
   // outputs decoded purely from registered path state, so no input reaches an output combinationally
   always_comb begin
      reserved    = '0;
      routeSelect = '0;
      outputBusy  = '0;
      for (int o = 0; o < OUTPUTS; o++) begin
         outputBusy[o] = st_q[o] == BUSY;
         routeSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = st_q[o] == BUSY ? REQUEST_WIDTH'(own_q[o]) : '0;
         if (st_q[o] == BUSY) reserved[own_q[o]] = 1'b1;
      end
   end
   // release busy outputs on the owner's tail handshake; idle outputs pick the first eligible input from ptr
   always_comb begin
      st_d    = st_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      grant_d = '0;
      idx     = '0;
      found   = 1'b0;
      s       = 0;
      for (int i = 0; i < INPUTS; i++) field[i] = req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH];
      for (int o = 0; o < OUTPUTS; o++) begin
         if (st_q[o] == BUSY) begin
            if (hs[own_q[o]]) begin
               st_d[o]  = IDLE;
               ptr_d[o] = own_q[o] == IW'(INPUTS-1) ? '0 : own_q[o] + 1'b1;
            end
         end else begin
            found = 1'b0;
            for (int k = 0; k < INPUTS; k++) begin
               s   = int'(ptr_q[o]) + k;
               s   = s >= INPUTS ? s - INPUTS : s;
               idx = IW'(s);
               if (!found && req_valid[idx] && field[idx] == REQUEST_WIDTH'(o) && !reserved[idx]) begin
                  found       = 1'b1;
                  st_d[o]     = BUSY;
                  own_d[o]    = idx;
                  grant_d[idx] = 1'b1;
               end
            end
         end
      end
   end
   // path state registers; reset drops every path immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < OUTPUTS; o++) begin
            st_q[o]  <= IDLE;
            own_q[o] <= '0;
            ptr_q[o] <= '0;
         end
         grant_q <= '0;
      end else begin
         st_q    <= st_d;
         own_q   <= own_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed and random checks of switch_allocator against an owner/pointer reference model
module tb_switch_allocator;
   localparam int N  = 4;
   localparam int RW = 32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0]    req_valid, valid_in, ready_in, tail_in;
   logic [N*RW-1:0] req_port;
   logic [N*RW-1:0] routeSelect;
   logic [N-1:0]    outputBusy, PortReserved, grant;
   int checks = 0;
   int failures = 0;
   int own [N];
   int ptr [N];
   logic [N-1:0] mgrant;
   int cnt, ng;
   int order [$];
   int when [$];
   int rr_exp [4] = '{0, 1, 3, 0};

   switch_allocator #(.INPUTS(N), .OUTPUTS(N), .REQUEST_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_port(req_port),
      .valid_in(valid_in), .ready_in(ready_in), .tail_in(tail_in),
      .routeSelect(routeSelect), .outputBusy(outputBusy),
      .PortReserved(PortReserved), .grant(grant));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [N*RW-1:0] act, logic [N*RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < N; o++) begin
         own[o] = -1;
         ptr[o] = 0;
      end
      mgrant = '0;
   endtask

   task automatic model_step();
      int nown [N];
      bit res [N];
      logic [N-1:0] hsv;
      hsv = valid_in & ready_in & tail_in;
      mgrant = '0;
      for (int i = 0; i < N; i++) res[i] = 0;
      for (int o = 0; o < N; o++) if (own[o] >= 0) res[own[o]] = 1;
      for (int o = 0; o < N; o++) begin
         nown[o] = own[o];
         if (own[o] >= 0) begin
            if (((hsv >> own[o]) & 4'd1) != 0) begin
               nown[o] = -1;
               ptr[o] = (own[o] + 1) % N;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (ptr[o] + k) % N;
               if (((req_valid >> i) & 4'd1) != 0 && req_port[i*RW +: RW] == 32'(o) && !res[i]) begin
                  nown[o] = i;
                  mgrant = mgrant | 4'(1 << i);
                  break;
               end
            end
         end
      end
      for (int o = 0; o < N; o++) own[o] = nown[o];
   endtask

   task automatic compare_all(string tag);
      logic [N-1:0] eb, er;
      logic [N*RW-1:0] ers;
      eb = '0;
      er = '0;
      ers = '0;
      for (int o = 0; o < N; o++) if (own[o] >= 0) begin
         eb = eb | 4'(1 << o);
         er = er | 4'(1 << own[o]);
         ers[o*RW +: RW] = 32'(own[o]);
      end
      check({tag, "_busy"}, outputBusy, eb);
      check({tag, "_reserved"}, PortReserved, er);
      check({tag, "_grant"}, grant, mgrant);
      check({tag, "_route"}, routeSelect, ers);
   endtask

   task automatic tick(string tag);
      model_step();
      @(posedge clk);
      #1;
      compare_all(tag);
      @(negedge clk);
   endtask

   task automatic clear();
      req_valid = '0;
      req_port = '0;
      valid_in = '0;
      ready_in = '0;
      tail_in = '0;
   endtask

   task automatic set_req(int i, int p);
      req_valid[i] = 1'b1;
      req_port[i*RW +: RW] = 32'(p);
   endtask

   task automatic handshake(logic [N-1:0] m);
      valid_in = m;
      ready_in = m;
      tail_in = m;
   endtask

   initial begin
      clear();
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_busy", outputBusy, 0);
      check("reset_reserved", PortReserved, 0);
      check("reset_grant", grant, 0);
      check("reset_route", routeSelect, 0);
      rst_n = 1'b1;
      // single request
      set_req(2, 1);
      tick("sr");
      check("sr_busy_c", outputBusy, 4'b0010);
      check("sr_route1_c", routeSelect[63:32], 2);
      check("sr_res_c", PortReserved, 4'b0100);
      check("sr_grant_c", grant, 4'b0100);
      clear();
      tick("sr_hold");
      check("sr_pulse_c", grant, 0);
      handshake(4'b0100);
      tick("sr_rel");
      check("sr_rel_busy_c", outputBusy, 0);
      check("sr_rel_res_c", PortReserved, 0);
      check("sr_rel_route_c", routeSelect, 0);
      // round-robin fairness on output 0, 3-flit packets
      clear();
      set_req(0, 0);
      set_req(1, 0);
      set_req(3, 0);
      cnt = 0;
      ng = 0;
      for (int c = 0; c < 60 && ng < 4; c++) begin
         valid_in = own[0] >= 0 ? 4'(1 << own[0]) : 4'd0;
         ready_in = valid_in;
         tail_in = cnt == 2 ? valid_in : 4'd0;
         tick("rr");
         if (valid_in != 0) cnt = cnt == 2 ? 0 : cnt + 1;
         for (int i = 0; i < N; i++) if (grant[i]) begin
            order.push_back(i);
            when.push_back(c);
            ng++;
         end
      end
      check("rr_count", ng, 4);
      for (int k = 0; k < ng && k < 4; k++) check("rr_order", order[k], rr_exp[k]);
      for (int k = 1; k < ng; k++) check("rr_gap", when[k] - when[k-1], 4);
      clear();
      handshake(4'b0001);
      tick("rr_rel");
      check("rr_rel_c", outputBusy, 0);
      // parallel paths
      clear();
      set_req(0, 3);
      set_req(3, 0);
      tick("par");
      check("par_grant_c", grant, 4'b1001);
      check("par_busy_c", outputBusy, 4'b1001);
      clear();
      handshake(4'b0001);
      tick("par_rel0");
      check("par_rel0_c", outputBusy, 4'b0001);
      handshake(4'b1000);
      tick("par_rel3");
      check("par_rel3_c", outputBusy, 0);
      // single-flit packet
      clear();
      set_req(1, 2);
      tick("sf");
      check("sf_busy_c", outputBusy, 4'b0100);
      clear();
      handshake(4'b0010);
      tick("sf_rel");
      check("sf_rel_c", outputBusy, 0);
      // invalid requested port
      clear();
      set_req(0, 7);
      tick("inv1");
      tick("inv2");
      check("inv_grant_c", grant, 0);
      check("inv_busy_c", outputBusy, 0);
      set_req(0, 2);
      tick("inv_fix");
      check("inv_fix_c", grant, 4'b0001);
      clear();
      handshake(4'b0001);
      tick("inv_rel");
      // asynchronous reset mid-packet
      clear();
      set_req(0, 1);
      set_req(2, 3);
      tick("rst_setup");
      check("rst_setup_c", outputBusy, 4'b1010);
      clear();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_busy", outputBusy, 0);
      check("rst_async_res", PortReserved, 0);
      check("rst_async_route", routeSelect, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 0);
      set_req(2, 0);
      tick("rst_rr");
      check("rst_rr_c", grant, 4'b0001);
      clear();
      handshake(4'b0001);
      tick("rst_rel");
      // random traffic
      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom);
         for (int i = 0; i < N; i++) req_port[i*RW +: RW] = 32'($urandom_range(0, 5));
         valid_in = 4'($urandom);
         ready_in = 4'($urandom);
         tail_in = 4'($urandom) & 4'($urandom);
         tick("rnd");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Sequential path allocator for the mux-based router switch. It collects per-input routing requests and arbitrates each output port round-robin among competing inputs. It holds each granted input→output path for a whole packet and releases it on the tail flit. It drives the `routeSelect`, `outputBusy` and `PortReserved` controls of the switch datapath and sits between the input buffers/route-compute stage and the switch.

## Interface
- `INPUTS`, 4, number of switch input ports.
- `OUTPUTS`, 4, number of switch output ports.
- `REQUEST_WIDTH`, 32, width of one requested-output index and of one `routeSelect` field.

Ports:
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input INPUTS: input i has a head flit requesting an output.
- `req_port` input INPUTS*REQUEST_WIDTH: field i holds the requested output index for input i.
- `valid_in` input INPUTS: flit-valid of each input (same signal the switch sees).
- `ready_in` input INPUTS: ready returned by the switch to each input.
- `tail_in` input INPUTS: the current flit on input i is a packet tail.
- `routeSelect` output OUTPUTS*REQUEST_WIDTH: field o holds the input index driving output o.
- `outputBusy` output OUTPUTS: output o is allocated.
- `PortReserved` output INPUTS: input i owns some output.
- `grant` output INPUTS: one-cycle pulse; input i was allocated this cycle.

## Operation
- Per output o: state IDLE or BUSY, owner index `own[o]`, round-robin pointer `ptr[o]` (range 0..INPUTS-1).
- Eligibility: input i is eligible for output o when all of these hold:
  - `req_valid[i]`
  - `req_port` field i == o
  - `PortReserved[i]` == 0
- Arbitration, every cycle, for every IDLE output: scan inputs ptr[o], ptr[o]+1, … modulo INPUTS. The first eligible input wins.
- No cross-output conflict is possible, because each input names exactly one output.
- On a win at the edge:
  - The output goes BUSY and `own[o]` = winner.
  - Next-cycle outputs: `outputBusy[o]`=1, `routeSelect` field o = winner (zero-extended), `PortReserved[winner]`=1, `grant[winner]`=1 for that cycle only.
- Release: an output is released when it is BUSY and `valid_in[own] & ready_in[own] & tail_in[own]` is seen at an edge. At that edge:
  - The output returns to IDLE.
  - `outputBusy[o]`=0, `PortReserved[own]`=0, `routeSelect` field o cleared to 0.
  - `ptr[o]` = (own+1) mod INPUTS.
- A head flit that is also a tail (single-flit packet) is released by the same rule as any other tail.
- Request values `req_port` ≥ OUTPUTS are never granted. That input stalls until the request changes or is dropped.
- A request may be dropped before grant with no side effect. After grant, `req_valid` is ignored for that input until release.
- Flits other than tails on the owner input, and any activity on non-owner inputs, do not affect a BUSY output.

## Timing
- Reset value of every output is 0, applied asynchronously: `routeSelect`, `outputBusy`, `PortReserved`, `grant`. All pointers and owners also reset to 0 and all outputs to IDLE. Reset is legal mid-packet and drops every path immediately.
- Grant latency: a request present at edge N is visible on the outputs after edge N when the output is IDLE. The first flit can transfer in the cycle following the grant.
- Release latency: the tail handshake at edge N makes the output IDLE after edge N.
- No re-grant happens in the release cycle. The earliest new grant of that output is at edge N+1, visible after N+1, giving one idle cycle between packets.
- A release and a new grant on different outputs in the same cycle are independent.
- An input released from output A may win output B at the next edge at the earliest.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single request:
  - Stimulus: reset, then `req_valid[2]`=1, port 1.
  - Expected: next cycle `outputBusy[1]`=1, `routeSelect[1]`=2, `PortReserved[2]`=1, `grant[2]` pulses once.
  - Then a tail handshake on input 2 clears all three after one edge.
- Round-robin fairness: inputs 0, 1 and 3 all hold requests for output 0, each packet 3 flits with tail on the third. Expected grant order is 0, 1, 3, 0, with exactly one idle cycle between packets.
- Parallel paths: input 0→output 3 and input 3→output 0 requested in the same cycle. Expected: both granted the same cycle, and a tail on one releases only its own path.
- Single-flit packet: input 1 sends head+tail to output 2 in the first cycle after grant. Expected: output 2 busy for exactly one cycle, then free.
- Invalid port: input 0 requests port 7 with OUTPUTS=4. Expected: no grant and all outputs stay 0. Changing the request to port 2 yields a grant next cycle.
- Reset mid-packet: assert `rst_n`=0 while two paths are BUSY. Expected: all outputs 0 immediately, without waiting for a clock edge. After release, output 0 goes to input 0 first, since pointers return to 0.
